score_encoder: RTL and testbench

Turns a Tetris line-clear event into the per-digit BCD increment consumed by the 4-digit BCD score accumulator.
- Points = base[lines] * (level+1), saturated to 9999.
- The binary result is converted to BCD by a sequential double-dabble engine.
- The result is presented on score_to_add for exactly one clock cycle. The accumulator adds its input every cycle, so score_to_add is all-zero at every other time.
- Sits between the game-logic line-clear detector and the score accumulator.

---
 rtl/score_encoder.sv | 148 ++++++++++++++
 tb/tb_score_encoder.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/score_encoder.sv
// score_encoder
// Converts a line-clear event into a one-cycle BCD increment for the
// 4-digit score accumulator. The points are base[lines] * (level+1),
// capped at SAT_MAX. The product is built by repeated addition. It is then
// converted to BCD with a double-dabble shifter that handles one bit per
// cycle.
//
// Ports:
//   clk          clock
//   reset        synchronous, active-high reset
//   clear_valid  line-clear event strobe, sampled only while ready=1
//   lines        number of lines cleared (1..4 accepted, others ignored)
//   level        current game level
//   ready        high while idle; an event can be accepted
//   add_pulse    high for the single cycle score_to_add carries a value
//   score_to_add BCD digits, [0]=ones .. [3]=thousands, bit 4 always 0
module score_encoder #(
  parameter int LEVEL_W = 4,
  parameter int BASE1   = 40,
  parameter int BASE2   = 100,
  parameter int BASE3   = 300,
  parameter int BASE4   = 1200,
  parameter int SAT_MAX = 9999
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear_valid,
  input  logic [2:0]         lines,
  input  logic [LEVEL_W-1:0] level,
  output logic               ready,
  output logic               add_pulse,
  output logic [3:0][4:0]    score_to_add
);

  typedef enum logic [1:0] {IDLE, MULT, CONV, EMIT} state_t;

  localparam logic [15:0] SAT_W = 16'(SAT_MAX);

  state_t               state_reg, state_next;
  logic [15:0]          base_reg;
  logic [15:0]          acc_reg;
  logic [LEVEL_W-1:0]   cnt_reg;
  logic [13:0]          bin_reg;
  logic [15:0]          bcd_reg;
  logic [3:0]           bitcnt_reg;

  logic                 event_ok;
  logic [15:0]          base_sel;
  logic [15:0]          acc_sum;
  logic [15:0]          acc_sat;
  logic [15:0]          bcd_adj;

  assign event_ok = clear_valid && (lines >= 3'd1) && (lines <= 3'd4);

  always_comb begin
    base_sel = 16'd0;
    case (lines)
      3'd1:    base_sel = 16'(BASE1);
      3'd2:    base_sel = 16'(BASE2);
      3'd3:    base_sel = 16'(BASE3);
      3'd4:    base_sel = 16'(BASE4);
      default: base_sel = 16'd0;
    endcase
  end

  // acc never exceeds SAT_MAX and base is small, so the 16-bit sum cannot wrap.
  assign acc_sum = acc_reg + base_reg;
  assign acc_sat = (acc_sum > SAT_W) ? SAT_W : acc_sum;

  // Double-dabble correction. Any nibble of 5 or more gets +3 before the
  // shift, so that the shift carries it into the next decade.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_adj
      assign bcd_adj[4*gi +: 4] = (bcd_reg[4*gi +: 4] >= 4'd5) ?
                                  bcd_reg[4*gi +: 4] + 4'd3 :
                                  bcd_reg[4*gi +: 4];
    end
  endgenerate

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (event_ok)             state_next = MULT;
      MULT: if (cnt_reg == '0)        state_next = CONV;
      CONV: if (bitcnt_reg == 4'd0)   state_next = EMIT;
      EMIT:                           state_next = IDLE;
      default:                        state_next = IDLE;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      base_reg   <= '0;
      acc_reg    <= '0;
      cnt_reg    <= '0;
      bin_reg    <= '0;
      bcd_reg    <= '0;
      bitcnt_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (event_ok) begin
            base_reg <= base_sel;
            cnt_reg  <= level;
            acc_reg  <= '0;
          end
        end
        MULT: begin
          acc_reg <= acc_sat;
          if (cnt_reg == '0) begin
            // Take the final sum of this cycle, not the stale acc_reg.
            bin_reg    <= acc_sat[13:0];
            bcd_reg    <= 16'h0000;
            bitcnt_reg <= 4'd13;
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        CONV: begin
          bcd_reg <= {bcd_adj[14:0], bin_reg[13]};
          bin_reg <= {bin_reg[12:0], 1'b0};
          if (bitcnt_reg != 4'd0) bitcnt_reg <= bitcnt_reg - 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Outputs decode registered state only.
  assign ready     = (state_reg == IDLE);
  assign add_pulse = (state_reg == EMIT);

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_out
      assign score_to_add[gi] = (state_reg == EMIT) ?
                                {1'b0, bcd_reg[4*gi +: 4]} : 5'd0;
    end
  endgenerate

endmodule

// File: tb/tb_score_encoder.sv
module tb_score_encoder;

  logic            clk = 1'b0;
  logic            reset;
  logic            clear_valid;
  logic [2:0]      lines;
  logic [3:0]      level;
  logic            ready;
  logic            add_pulse;
  logic [3:0][4:0] score_to_add;

  score_encoder #(.LEVEL_W(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .clear_valid  (clear_valid),
    .lines        (lines),
    .level        (level),
    .ready        (ready),
    .add_pulse    (add_pulse),
    .score_to_add (score_to_add)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [19:0] digits;
    int          due;
    int          pts;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   pulses = 0;
  int   pushed = 0;

  // Expected BCD pattern {thousands, hundreds, tens, ones} from a points value
  function automatic logic [19:0] to_digits(input int n);
    return {5'(n / 1000 % 10), 5'(n / 100 % 10), 5'(n / 10 % 10), 5'(n % 10)};
  endfunction

  // Monitor: pops the scoreboard on every pulse and checks output is idle-zero otherwise
  always @(negedge clk) begin
    if (!reset && add_pulse) begin
      pulses++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse cyc=%0d got=%h required=no pulse", cyc, score_to_add);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (score_to_add !== e.digits) begin
          errors++;
          $display("FAIL digits pts=%0d got=%h required=%h", e.pts, score_to_add, e.digits);
        end else
          $display("pulse pts=%0d digits=%h cyc=%0d", e.pts, score_to_add, cyc);
        checks++;
        if (cyc != e.due) begin
          errors++;
          $display("FAIL pulse_timing pts=%0d got_cyc=%0d required_cyc=%0d", e.pts, cyc, e.due);
        end
      end
    end else begin
      checks++;
      if (score_to_add !== 20'd0) begin
        errors++;
        $display("FAIL zero_when_idle cyc=%0d got=%h required=0", cyc, score_to_add);
      end
    end
  end

  task automatic wait_ready();
    int t = 0;
    while (ready !== 1'b1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_timeout got=%b required=1", ready);
    end
  endtask

  // Issue one event once ready; push an expectation if it should be accepted.
  task automatic send(input logic [2:0] l, input logic [3:0] lv, input int pts, input bit expect_emit);
    int e0;
    wait_ready();
    lines = l;
    level = lv;
    clear_valid = 1'b1;
    @(posedge clk);
    #1;
    e0 = cyc;
    if (expect_emit) begin
      exp_q.push_back('{to_digits(pts), e0 + int'(lv) + 15, pts});
      pushed++;
    end
    $display("event lines=%0d level=%0d pts=%0d accept_cyc=%0d", l, lv, pts, e0);
    @(negedge clk);
    clear_valid = 1'b0;
  endtask

  task automatic check_bit(input string name, input logic got, input logic req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s got=%b required=%b", name, got, req);
    end
  endtask

  initial begin
    int t;
    reset = 1'b1;
    clear_valid = 1'b0;
    lines = 3'd0;
    level = 4'd0;
    repeat (3) @(negedge clk);
    check_bit("reset_ready", ready, 1'b1);
    check_bit("reset_pulse", add_pulse, 1'b0);
    reset = 1'b0;
    @(negedge clk);

    // Reset mid-conversion aborts the pending event
    send(3'd4, 4'd3, 4800, 1'b0);
    repeat (8) @(negedge clk);
    check_bit("busy_before_reset", ready, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    check_bit("abort_ready", ready, 1'b1);
    check_bit("abort_pulse", add_pulse, 1'b0);
    checks++;
    if (score_to_add !== 20'd0) begin
      errors++;
      $display("FAIL abort_score got=%h required=0", score_to_add);
    end
    reset = 1'b0;
    repeat (40) @(negedge clk);

    // Directed vectors (hand-computed points)
    send(3'd1, 4'd0, 40, 1'b1);
    send(3'd3, 4'd2, 900, 1'b1);
    send(3'd2, 4'd15, 1600, 1'b1);
    send(3'd4, 4'd9, 9999, 1'b1);
    send(3'd4, 4'd15, 9999, 1'b1);
    send(3'd3, 4'd0, 300, 1'b1);

    // Invalid line counts are ignored
    send(3'd0, 4'd2, 0, 1'b0);
    check_bit("ignore_lines0_ready", ready, 1'b1);
    send(3'd5, 4'd2, 0, 1'b0);
    check_bit("ignore_lines5_ready", ready, 1'b1);

    // Event while busy is dropped
    send(3'd1, 4'd1, 80, 1'b1);
    @(negedge clk);
    lines = 3'd4;
    level = 4'd0;
    clear_valid = 1'b1;
    @(negedge clk);
    clear_valid = 1'b0;

    // Back-to-back
    send(3'd1, 4'd0, 40, 1'b1);
    send(3'd2, 4'd1, 200, 1'b1);

    t = 0;
    while (exp_q.size() != 0 && t < 500) begin
      @(negedge clk);
      t++;
    end
    repeat (40) @(negedge clk);
    checks++;
    if (exp_q.size() != 0 || pulses != pushed) begin
      errors++;
      $display("FAIL pulse_count got=%0d required=%0d", pulses, pushed);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
